// File: rtl/fetch_buf_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_buf_pkg;

  localparam int INS_W = 32;
  localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0013;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  function automatic logic word_aligned(input logic [1:0] lo);
    return lo == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_buf_if.sv
// Redirect and fetch-to-decode interfaces for fetch_buf.
interface fetch_redirect_if #(
  parameter int ADDR_W = 32
);
  logic              jump_taken;
  logic [ADDR_W-1:0] jump_target;

  modport master (output jump_taken, output jump_target);
  modport slave  (input  jump_taken, input  jump_target);
endinterface

interface fetch_id_if #(
  parameter int ADDR_W = 32
);
  logic                              valid;
  logic                              ready;
  logic [ADDR_W-1:0]                 pc;
  logic [fetch_buf_pkg::INS_W-1:0]   ins;
  logic                              misaligned;

  modport master (output valid, output pc, output ins, output misaligned, input ready);
  modport slave  (input valid, input pc, input ins, input misaligned, output ready);
endinterface

// File: rtl/fetch_fifo.sv
// Instruction queue: circular buffer with combinational head read.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count_reg != CNT_W'(DEPTH));
  assign do_pop  = pop && (count_reg != '0);

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/fetch_buf.sv
// Fetch unit: issues sequential reads, queues returned words for decode,
// and handles aligned/misaligned redirects.
module fetch_buf
  import fetch_buf_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INS_W-1:0]  NOP      = NOP_INS
) (
  input  logic              clk,
  input  logic              rst,
  fetch_redirect_if.slave   mb_if,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INS_W-1:0]  imem_data,
  fetch_id_if.master        if_id,
  output logic              pipe_flush
);
  localparam int ENT_W = ADDR_W + INS_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic              inflight_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;
  logic              marker_pending_reg;
  logic [ADDR_W-1:0] marker_pc_reg;
  logic              flush_reg;

  logic              redirect;
  logic              tgt_aligned;
  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              fifo_push;
  logic              fifo_pop;
  logic [ENT_W-1:0]  fifo_wdata;
  logic [ENT_W-1:0]  fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;

  // A redirect arriving while the flush indication is up is dropped.
  assign redirect    = mb_if.jump_taken && !flush_reg && !rst;
  assign tgt_aligned = word_aligned(mb_if.jump_target[1:0]);

  // Reserve a slot for the response still in flight before issuing another read.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
  assign issue     = !rst && (state_reg == ST_RUN) && !redirect
                     && (occupancy < (CNT_W+1)'(DEPTH));

  // A pending marker and a live response never coincide: the redirect
  // that created the marker suppressed the read that would return now.
  assign fifo_push  = !rst && (marker_pending_reg || (inflight_reg && !redirect));
  assign fifo_wdata = marker_pending_reg ? {marker_pc_reg, NOP, 1'b1}
                                         : {inflight_pc_reg, imem_data, 1'b0};
  assign fifo_pop   = if_id.ready && !fifo_empty;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= ST_RUN;
      pc_reg             <= RESET_PC;
      inflight_reg       <= 1'b0;
      inflight_pc_reg    <= RESET_PC;
      marker_pending_reg <= 1'b0;
      marker_pc_reg      <= RESET_PC;
      flush_reg          <= 1'b1;
    end else begin
      flush_reg          <= redirect;
      marker_pending_reg <= 1'b0;
      inflight_reg       <= issue;
      if (issue) begin
        inflight_pc_reg <= pc_reg;
        pc_reg          <= pc_reg + ADDR_W'(4);
      end
      if (redirect) begin
        if (tgt_aligned) begin
          state_reg <= ST_RUN;
          pc_reg    <= mb_if.jump_target;
        end else begin
          state_reg          <= ST_HALT;
          marker_pending_reg <= 1'b1;
          marker_pc_reg      <= mb_if.jump_target;
        end
      end
    end
  end

  assign imem_req         = issue;
  assign imem_addr        = pc_reg;
  assign pipe_flush       = flush_reg;
  assign if_id.valid      = !fifo_empty;
  assign if_id.pc         = fifo_rdata[ENT_W-1 -: ADDR_W];
  assign if_id.ins        = fifo_rdata[INS_W:1];
  assign if_id.misaligned = !fifo_empty && fifo_rdata[0];

endmodule

// File: tb/tb_fetch_buf.sv
// Directed bench for fetch_buf: sequential fetch, stall, redirects, reset, pc wrap.
module tb_fetch_buf;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        mis;
  } acc_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        pipe_flush;
  logic        imem8_req;
  logic [7:0]  imem8_addr;
  logic [31:0] imem8_data;
  logic        pipe8_flush;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_issue = 0;
  acc_t acc_q[$];
  logic [7:0] pc8_q[$];

  fetch_redirect_if #(.ADDR_W(32)) mb ();
  fetch_id_if       #(.ADDR_W(32)) id ();
  fetch_redirect_if #(.ADDR_W(8))  mb8 ();
  fetch_id_if       #(.ADDR_W(8))  id8 ();

  fetch_buf #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0), .NOP(32'h0000_0013)) dut (
    .clk        (clk),
    .rst        (rst),
    .mb_if      (mb),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .if_id      (id),
    .pipe_flush (pipe_flush)
  );

  fetch_buf #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'hF8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .mb_if      (mb8),
    .imem_req   (imem8_req),
    .imem_addr  (imem8_addr),
    .imem_data  (imem8_data),
    .if_id      (id8),
    .pipe_flush (pipe8_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns the address as data, one cycle later.
  always @(posedge clk) begin
    imem_data  <= imem_addr;
    imem8_data <= {24'h0, imem8_addr};
  end

  always @(negedge clk) begin
    if (imem_req) n_issue++;
    if (id.valid && id.ready) begin
      acc_q.push_back({id.pc, id.ins, id.misaligned});
      $display("accept pc=%h ins=%h mis=%b", id.pc, id.ins, id.misaligned);
    end
    if (id8.valid && id8.ready && pc8_q.size() < 4) begin
      pc8_q.push_back(id8.pc);
      $display("accept8 pc=%h ins=%h", id8.pc, id8.ins);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic acc_t acc_at(input int i);
    acc_t a;
    a = 'x;
    if (i >= 0 && i < acc_q.size()) a = acc_q[i];
    return a;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   base;
    int   iss0;
    int   lm;
    int   n10;
    logic found;
    acc_t a;

    rst = 1'b1;
    mb.jump_taken = 1'b0;  mb.jump_target = '0;  id.ready = 1'b1;
    mb8.jump_taken = 1'b0; mb8.jump_target = '0; id8.ready = 1'b1;

    // Reset state
    repeat (3) cyc();
    @(negedge clk);
    check_eq("rst_req",   imem_req, 0);
    check_eq("rst_valid", id.valid, 0);
    check_eq("rst_mis",   id.misaligned, 0);
    check_eq("rst_flush", pipe_flush, 1);

    // Release: reads 0,4,8..; first valid on cycle 2
    cyc(); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      check_eq($sformatf("c%0d_req", k),   imem_req, 1);
      check_eq($sformatf("c%0d_addr", k),  imem_addr, 32'(4 * k));
      check_eq($sformatf("c%0d_flush", k), pipe_flush, (k == 0));
      check_eq($sformatf("c%0d_valid", k), id.valid, (k >= 2));
      if (k >= 2) begin
        check_eq($sformatf("c%0d_pc", k),  id.pc,  32'(4 * (k - 2)));
        check_eq($sformatf("c%0d_ins", k), id.ins, 32'(4 * (k - 2)));
      end
    end

    // Stall for 10 cycles: queue fills to DEPTH, reads stop
    cyc(); id.ready = 1'b0;
    repeat (9) cyc();
    check_eq("stall_held", n_issue - acc_q.size(), 4);
    @(negedge clk);
    check_eq("stall_req",   imem_req, 0);
    check_eq("stall_valid", id.valid, 1);
    check_eq("stall_head",  id.pc, 32'(4 * acc_q.size()));
    cyc(); id.ready = 1'b1;
    repeat (8) cyc();
    for (int i = 0; i < acc_q.size(); i++) begin
      a = acc_at(i);
      check_eq($sformatf("seq%0d_pc", i),  a.pc,  32'(4 * i));
      check_eq($sformatf("seq%0d_ins", i), a.ins, 32'(4 * i));
      check_eq($sformatf("seq%0d_mis", i), a.mis, 0);
    end

    // Aligned redirect to 0x100 while the read of 0x10 is in flight
    rst = 1'b1;
    cyc(); cyc(); rst = 1'b0; base = acc_q.size();
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (t > 0) cyc();
      @(negedge clk);
      if (imem_req && imem_addr == 32'h10) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("wait_rd10", found, 1);
    cyc(); mb.jump_taken = 1'b1; mb.jump_target = 32'h100;
    @(negedge clk);
    check_eq("rd1_req",   imem_req, 0);
    check_eq("rd1_flush", pipe_flush, 0);
    cyc(); mb.jump_taken = 1'b0;
    @(negedge clk);
    check_eq("rd1_flush_hi", pipe_flush, 1);
    check_eq("rd1_valid",    id.valid, 0);
    check_eq("rd1_addr",     imem_addr, 32'h100);
    check_eq("rd1_req_next", imem_req, 1);
    cyc();
    @(negedge clk);
    check_eq("rd1_flush_lo", pipe_flush, 0);
    repeat (4) cyc();
    a = acc_at(base + 3); check_eq("rd1_pop_same", a.pc, 32'hC);
    a = acc_at(base + 4); check_eq("rd1_first",    a.pc, 32'h100);
    a = acc_at(base + 5); check_eq("rd1_second",   a.pc, 32'h104);
    n10 = 0;
    for (int i = base; i < acc_q.size(); i++) begin
      a = acc_at(i);
      if (a.pc == 32'h10) n10++;
    end
    check_eq("rd1_no_0x10", n10, 0);

    // Misaligned redirect to 0x102: one NOP marker, fetch halts
    cyc(); mb.jump_taken = 1'b1; mb.jump_target = 32'h102;
    @(negedge clk);
    cyc(); mb.jump_taken = 1'b0; lm = acc_q.size(); iss0 = n_issue;
    @(negedge clk);
    check_eq("mis_valid0", id.valid, 0);
    check_eq("mis_req0",   imem_req, 0);
    cyc();
    @(negedge clk);
    check_eq("mis_head_valid", id.valid, 1);
    check_eq("mis_head_pc",    id.pc, 32'h102);
    check_eq("mis_head_ins",   id.ins, 32'h13);
    check_eq("mis_head_flag",  id.misaligned, 1);
    repeat (5) cyc();
    check_eq("halt_no_reads", n_issue - iss0, 0);
    check_eq("halt_one_entry", acc_q.size() - lm, 1);
    a = acc_at(lm);
    check_eq("mis_log_pc",  a.pc, 32'h102);
    check_eq("mis_log_mis", a.mis, 1);
    mb.jump_taken = 1'b1; mb.jump_target = 32'h200;
    @(negedge clk);
    check_eq("rd2_req", imem_req, 0);
    cyc(); mb.jump_taken = 1'b0;
    @(negedge clk);
    check_eq("rd2_resume_req",  imem_req, 1);
    check_eq("rd2_resume_addr", imem_addr, 32'h200);
    repeat (4) cyc();
    a = acc_at(lm + 1); check_eq("rd2_first",  a.pc, 32'h200);
    a = acc_at(lm + 2); check_eq("rd2_second", a.pc, 32'h204);

    // Reset with 3 entries queued
    id.ready = 1'b0; mb.jump_taken = 1'b1; mb.jump_target = 32'h300;
    @(negedge clk);
    cyc(); mb.jump_taken = 1'b0; iss0 = n_issue;
    repeat (4) cyc();
    check_eq("fill_reads", n_issue - iss0, 4);
    rst = 1'b1;
    @(negedge clk);
    check_eq("q3_valid", id.valid, 1);
    check_eq("q3_head",  id.pc, 32'h300);
    cyc();
    @(negedge clk);
    check_eq("q3_rst_valid", id.valid, 0);
    check_eq("q3_rst_flush", pipe_flush, 1);
    cyc(); rst = 1'b0; id.ready = 1'b1; base = acc_q.size();
    @(negedge clk);
    check_eq("q3_restart_req",  imem_req, 1);
    check_eq("q3_restart_addr", imem_addr, 32'h0);
    repeat (5) cyc();
    a = acc_at(base);     check_eq("q3_pc0", a.pc, 32'h0);
    a = acc_at(base + 1); check_eq("q3_pc1", a.pc, 32'h4);
    a = acc_at(base + 2); check_eq("q3_pc2", a.pc, 32'h8);

    // 8-bit PC wraps from 0xFC to 0x00
    check_eq("w8_count", pc8_q.size(), 4);
    if (pc8_q.size() == 4) begin
      check_eq("w8_pc0", pc8_q[0], 8'hF8);
      check_eq("w8_pc1", pc8_q[1], 8'hFC);
      check_eq("w8_pc2", pc8_q[2], 8'h00);
      check_eq("w8_pc3", pc8_q[3], 8'h04);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
